// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared widths, defaults and state encoding for the APB
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_AW      = 9;
    localparam int APB_DW      = 8;
    localparam int APB_TIMEOUT = 255;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; first unmasked request at or
//               after the priority pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    logic [NREQ-1:0] w_req;

    assign w_req = req & ~mask;

    // Walk offsets from the pointer; the first live request found is granted.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!valid && w_req[k] && (((int'(ptr) + off) % NREQ) == k)) begin
                    gnt[k] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// Module      : apb_req_arbiter
// Description : Shares one APB master among NREQ requesters with round-robin
//               arbitration, completion/timeout tracking and done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               tx,
    output logic [AW-1:0]      apb_slv_paddr,
    output logic [DW-1:0]      apb_pwdata,
    output logic               apb_swrite,
    input  logic               psel,
    input  logic               pen,
    input  logic               pready,
    input  logic               pslverr,
    input  logic [DW-1:0]      prdata
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [PW-1:0]   r_ptr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_write;
    logic            r_err;

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_win;
    logic            w_win_valid;
    logic [PW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_write;
    logic            w_wait_cyc;
    logic            w_complete;
    logic            w_timeout;
    logic            w_load;
    logic            w_finish;

    assign w_wait_cyc = (r_state == ARB_XFER) && psel && pen && !pready;
    assign w_complete = (r_state == ARB_XFER) && psel && pen && pready;

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            logic [TW-1:0] r_wait;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait <= '0;
                end else if (w_wait_cyc && !w_timeout) begin
                    r_wait <= r_wait + 1'b1;
                end else begin
                    r_wait <= '0;
                end
            end

            // Fires on the TIMEOUT-th consecutive wait cycle; pready high never times out.
            assign w_timeout = w_wait_cyc && (r_wait == TW'(TIMEOUT - 1));
        end
    endgenerate

    // The current owner is excluded when re-arbitrating at completion.
    assign w_mask = (r_state == ARB_XFER) ? r_gnt : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req   (req),
        .mask  (w_mask),
        .ptr   (r_ptr),
        .gnt   (w_win),
        .valid (w_win_valid)
    );

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win[k]) begin
                w_ptr_nxt   = (k == NREQ - 1) ? '0 : PW'(k + 1);
                w_sel_addr  = req_addr[k*AW +: AW];
                w_sel_wdata = req_wdata[k*DW +: DW];
                w_sel_write = req_write[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (w_complete) begin
                    w_state_nxt = w_win_valid ? ARB_XFER : ARB_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        w_load   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ARB_IDLE: w_load = w_win_valid;
            ARB_XFER: begin
                w_load   = w_complete && w_win_valid;
                w_finish = w_complete || w_timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_finish) begin
                r_done <= r_gnt;
                r_err  <= w_complete ? pslverr : 1'b1;
                if (w_complete && !r_write) begin
                    r_rdata <= prdata;
                end
            end
            if (w_load) begin
                r_gnt   <= w_win;
                r_ptr   <= w_ptr_nxt;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_write <= w_sel_write;
            end else if (w_finish) begin
                r_gnt <= '0;
            end
        end
    end

    assign tx            = (r_state == ARB_XFER);
    assign gnt           = r_gnt;
    assign done          = r_done;
    assign rdata         = r_rdata;
    assign err           = r_err;
    assign apb_slv_paddr = r_addr;
    assign apb_pwdata    = r_wdata;
    assign apb_swrite    = r_write;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Scoreboard bench with APB master/slave models for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int TO   = 4;

    localparam logic [1:0] M_IDLE   = 2'd0;
    localparam logic [1:0] M_SETUP  = 2'd1;
    localparam logic [1:0] M_ACCESS = 2'd2;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    req       = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err;
    logic               tx;
    logic [AW-1:0]      apb_slv_paddr;
    logic [DW-1:0]      apb_pwdata;
    logic               apb_swrite;
    logic               psel;
    logic               pen;
    logic               pready;
    logic               pslverr;
    logic [DW-1:0]      prdata;

    logic [1:0]    m_state;
    int            wcnt;
    int            wait_cfg = 0;
    logic          stuck    = 1'b0;
    logic [AW-1:0] err_addr = 9'h1FF;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   reps[NREQ];
    exp_t sb[$];
    exp_t e;
    logic [AW-1:0] cap_addr;
    logic          cap_write;
    logic [DW-1:0] cap_wdata;
    logic [DW-1:0] setup_wdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_req_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .done          (done),
        .rdata         (rdata),
        .err           (err),
        .tx            (tx),
        .apb_slv_paddr (apb_slv_paddr),
        .apb_pwdata    (apb_pwdata),
        .apb_swrite    (apb_swrite),
        .psel          (psel),
        .pen           (pen),
        .pready        (pready),
        .pslverr       (pslverr),
        .prdata        (prdata)
    );

    // APB master: IDLE -> SETUP -> ACCESS, chaining while tx stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:   if (tx) m_state <= M_SETUP;
                M_SETUP:  m_state <= tx ? M_ACCESS : M_IDLE;
                M_ACCESS: if (pready || !tx) m_state <= tx ? M_SETUP : M_IDLE;
                default:  m_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
        end else if (m_state == M_ACCESS && !pready) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    assign psel    = (m_state != M_IDLE);
    assign pen     = (m_state == M_ACCESS);
    assign pready  = (m_state == M_ACCESS) && !stuck && (wcnt >= wait_cfg);
    assign pslverr = pready && (apb_slv_paddr == err_addr);
    assign prdata  = apb_slv_paddr[7:0] ^ 8'hA0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [AW-1:0] a, input logic wr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input logic er, input int c);
        exp_t x;
        x.idx = idx; x.addr = a; x.wr = wr; x.wdata = wd;
        x.rdata = rd; x.err = er; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic arm(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd);
        req_addr[i*AW +: AW]  = a;
        req_write[i]          = wr;
        req_wdata[i*DW +: DW] = wd;
        req[i]                = 1'b1;
    endtask

    // Requesters drop REQ in the DONE cycle unless they have repeats left.
    task automatic next_cycle();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (done[i] && !rst) begin
                if (reps[i] > 0) reps[i]--;
                else req[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || req != 0 || tx || m_state != M_IDLE) && k < budget) begin
            next_cycle();
            k++;
        end
        chk("drain_in_budget", 32'(k < budget), 1);
    endtask

    // Monitor: pops one expectation per DONE pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(done), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_vec", 32'(done), 32'(1 << e.idx));
                        chk("done_cycle", cyc, e.cyc);
                        chk("rdata", 32'(rdata), 32'(e.rdata));
                        chk("err", 32'(err), 32'(e.err));
                        chk("bus_addr", 32'(cap_addr), 32'(e.addr));
                        chk("bus_write", 32'(cap_write), 32'(e.wr));
                        if (e.wr) begin
                            chk("bus_wdata_access", 32'(cap_wdata), 32'(e.wdata));
                            chk("bus_wdata_setup", 32'(setup_wdata), 32'(e.wdata));
                        end
                    end
                end
                if (m_state == M_ACCESS) begin
                    cap_addr  = apb_slv_paddr;
                    cap_write = apb_swrite;
                    cap_wdata = apb_pwdata;
                end
                if (m_state == M_SETUP) setup_wdata = apb_pwdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int t0;
        int drops;
        for (int i = 0; i < NREQ; i++) reps[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();
        chk("rst_tx", 32'(tx), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_swrite", 32'(apb_swrite), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_paddr", 32'(apb_slv_paddr), 0);
        chk("rst_pwdata", 32'(apb_pwdata), 0);

        // Fairness: all four request, requester 0 asks twice.
        arm(0, 9'h011, 1'b0, 8'h00);
        arm(1, 9'h122, 1'b1, 8'h71);
        arm(2, 9'h033, 1'b0, 8'h00);
        arm(3, 9'h144, 1'b1, 8'h94);
        reps[0] = 1;
        t0 = cyc;
        push(0, 9'h011, 1'b0, 8'h00, 8'hB1, 1'b0, t0 + 4);
        push(1, 9'h122, 1'b1, 8'h71, 8'hB1, 1'b0, t0 + 6);
        push(2, 9'h033, 1'b0, 8'h00, 8'h93, 1'b0, t0 + 8);
        push(3, 9'h144, 1'b1, 8'h94, 8'h93, 1'b0, t0 + 10);
        push(0, 9'h011, 1'b0, 8'h00, 8'hB1, 1'b0, t0 + 12);
        drops = 0;
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            if (k == 1) chk("fair_first_gnt", 32'(gnt), 32'h1);
            if (tx !== 1'b1) drops++;
        end
        chk("fair_tx_held", drops, 0);
        drain(40);

        // Single zero-wait read to slave 2.
        arm(0, 9'h105, 1'b0, 8'h00);
        t0 = cyc;
        push(0, 9'h105, 1'b0, 8'h00, 8'hA5, 1'b0, t0 + 4);
        chk("single_tx_c0", 32'(tx), 0);
        next_cycle();
        chk("single_tx_c1", 32'(tx), 1);
        chk("single_gnt_c1", 32'(gnt), 32'h1);
        drain(20);

        // Write with three wait states.
        wait_cfg = 3;
        arm(2, 9'h010, 1'b1, 8'h3C);
        t0 = cyc;
        push(2, 9'h010, 1'b1, 8'h3C, 8'hA5, 1'b0, t0 + 7);
        drain(30);
        wait_cfg = 0;

        // Timeout with PREADY stuck low.
        stuck = 1'b1;
        arm(3, 9'h1F0, 1'b0, 8'h00);
        t0 = cyc;
        push(3, 9'h1F0, 1'b0, 8'h00, 8'hA5, 1'b1, t0 + 7);
        repeat (7) next_cycle();
        chk("to_tx_low", 32'(tx), 0);
        next_cycle();
        chk("to_master_idle", 32'(m_state), 32'(M_IDLE));
        stuck = 1'b0;
        drain(20);

        // Slave error, then the pending requester follows with no gap.
        err_addr = 9'h0EE;
        arm(1, 9'h0EE, 1'b0, 8'h00);
        arm(2, 9'h022, 1'b0, 8'h00);
        t0 = cyc;
        push(1, 9'h0EE, 1'b0, 8'h00, 8'h4E, 1'b1, t0 + 4);
        push(2, 9'h022, 1'b0, 8'h00, 8'h82, 1'b0, t0 + 6);
        repeat (4) next_cycle();
        chk("err_no_gap_tx", 32'(tx), 1);
        chk("err_next_gnt", 32'(gnt), 32'h4);
        drain(20);
        err_addr = 9'h1FF;

        // Reset during ACCESS; pointer must restart at requester 0.
        wait_cfg = 3;
        arm(2, 9'h0AB, 1'b0, 8'h00);
        repeat (4) next_cycle();
        rst = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx), 0);
        chk("rstmid_gnt", 32'(gnt), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_rdata", 32'(rdata), 0);
        req = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        wait_cfg = 0;
        next_cycle();
        arm(1, 9'h105, 1'b0, 8'h00);
        arm(3, 9'h1C0, 1'b1, 8'h55);
        t0 = cyc;
        push(1, 9'h105, 1'b0, 8'h00, 8'hA5, 1'b0, t0 + 4);
        push(3, 9'h1C0, 1'b1, 8'h55, 8'hA5, 1'b0, t0 + 6);
        next_cycle();
        chk("postrst_first_gnt", 32'(gnt), 32'h2);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
